cpu_clk_ctrl: RTL and testbench

- Run-control sequencer for the multi-cycle CPU clock domain.
- Produces a single-cycle clock-enable pulse (cpu_ce) on the system clock instead of a gated or derived clock.
- Four modes: halt, single-step (button), slow run (programmable divisor), fast run (every cycle).
- Sits between the board clock/buttons/switches and the CPU core; also counts retired CPU cycles for display.

---
 rtl/cpu_clk_pkg.sv | 34 +++
 rtl/cpu_clk_ctrl_if.sv | 51 +++++
 rtl/ce_rate_gen.sv | 55 +++++
 rtl/cpu_clk_ctrl.sv | 130 +++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_clk_pkg.sv
// ----------------------------------------------------------------------------
// cpu_clk_pkg
// Shared definitions for the CPU run-control sequencer: mode encodings,
// sequencer state type, default slow-mode divisor and a mode decode helper.
// ----------------------------------------------------------------------------
package cpu_clk_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    // 1 Hz at a 100 MHz system clock
    localparam int unsigned DEF_DIV = 100_000_000;

    typedef enum logic [1:0] {
        StHalt = 2'b00,
        StStep = 2'b01,
        StSlow = 2'b10,
        StFast = 2'b11
    } state_e;

    function automatic state_e mode_to_state(input logic [1:0] mode);
        state_e st;
        unique case (mode)
            MODE_HALT: st = StHalt;
            MODE_STEP: st = StStep;
            MODE_SLOW: st = StSlow;
            default:   st = StFast;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// ----------------------------------------------------------------------------
// cpu_clk_ctrl_if
// Control/status bundle of the CPU run-control sequencer.
//   master : board side (drives mode, buttons, divisor load, halt request)
//   slave  : cpu_clk_ctrl (drives cpu_ce, running, halted, cycle_cnt)
// With CPU_CLK_CTRL_BREAKPOINT_EN defined the bundle also carries pc, bp_wr,
// bp_addr and bp_on (inputs to the sequencer).
// ----------------------------------------------------------------------------
interface cpu_clk_ctrl_if #(
    parameter int unsigned DIV_W = 32,
    parameter int unsigned CYC_W = 32
);

    logic [1:0]       mode;
    logic             step_btn;
    logic             div_load;
    logic [DIV_W-1:0] div_val;
    logic             halt_req;
    logic             cpu_ce;
    logic             running;
    logic             halted;
    logic [CYC_W-1:0] cycle_cnt;

`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
    logic [31:0]      pc;
    logic             bp_wr;
    logic [31:0]      bp_addr;
    logic             bp_on;

    modport master (
        output mode, step_btn, div_load, div_val, halt_req, pc, bp_wr, bp_addr, bp_on,
        input  cpu_ce, running, halted, cycle_cnt
    );

    modport slave (
        input  mode, step_btn, div_load, div_val, halt_req, pc, bp_wr, bp_addr, bp_on,
        output cpu_ce, running, halted, cycle_cnt
    );
`else
    modport master (
        output mode, step_btn, div_load, div_val, halt_req,
        input  cpu_ce, running, halted, cycle_cnt
    );

    modport slave (
        input  mode, step_btn, div_load, div_val, halt_req,
        output cpu_ce, running, halted, cycle_cnt
    );
`endif

endinterface

// File: rtl/ce_rate_gen.sv
// ----------------------------------------------------------------------------
// ce_rate_gen
// Slow-mode rate generator: divisor register, tick counter and terminal-count
// strobe.
//   clk, rst  : system clock, async active-high reset
//   clear_i   : discard the running count (tick -> 0)
//   load_i    : load val_i into the divisor (0 stored as 1), tick -> 0
//   val_i     : new divisor
//   enable_i  : count this cycle (sequencer is in / entering slow run)
//   tc_o      : combinational, high in the cycle tick == divisor-1
// ----------------------------------------------------------------------------
module ce_rate_gen #(
    parameter int unsigned DIV_W   = 32,
    parameter int unsigned DEF_DIV = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] val_i,
    input  logic             enable_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] tick_q, tick_d;

    // A cycle that loads or clears never fires; the count restarts from 0.
    assign tc_o = enable_i & ~clear_i & ~load_i & (tick_q == div_q - DIV_W'(1));

    always_comb begin
        div_d = div_q;
        if (load_i) begin
            div_d = (val_i == '0) ? DIV_W'(1) : val_i;
        end
    end

    always_comb begin
        tick_d = tick_q + DIV_W'(1);
        if (clear_i || load_i || !enable_i || tc_o) begin
            tick_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= DIV_W'(DEF_DIV);
            tick_q <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_clk_ctrl
// Run-control sequencer for the multi-cycle CPU. Issues a registered,
// single-cycle clock enable (cpu_ce) on the system clock in one of four modes:
// halt, single-step (button), slow run (programmable divisor), fast run.
// Ports:
//   clk, rst : system clock, async active-high reset
//   bus      : cpu_clk_ctrl_if.slave
//              in : mode, step_btn, div_load, div_val, halt_req
//              out: cpu_ce, running, halted, cycle_cnt
// Optional: CPU_CLK_CTRL_BREAKPOINT_EN adds a PC breakpoint (pc, bp_wr,
// bp_addr, bp_on on the bus) that sets halted like halt_req does.
// ----------------------------------------------------------------------------
module cpu_clk_ctrl #(
    parameter int unsigned DIV_W   = 32,
    parameter int unsigned DEF_DIV = cpu_clk_pkg::DEF_DIV,
    parameter int unsigned CYC_W   = 32
) (
    input  logic        clk,
    input  logic        rst,
    cpu_clk_ctrl_if.slave bus
);

    import cpu_clk_pkg::*;

    state_e           state_q, state_d;
    logic             cpu_ce_q, cpu_ce_d;
    logic             running_q, running_d;
    logic             halted_q, halted_d;
    logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             step_q;
    logic             step_edge;
    logic             slow_tc;
    logic             bp_hit;
    logic             halt_set;

    assign step_edge = bus.step_btn & ~step_q;

`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
    logic [31:0] bp_q, bp_d;

    always_comb begin
        bp_d = bp_q;
        if (bus.bp_wr) begin
            bp_d = bus.bp_addr;
        end
    end

    assign bp_hit = bus.bp_on & running_q & (bus.pc == bp_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_q <= '0;
        end else begin
            bp_q <= bp_d;
        end
    end
`else
    assign bp_hit = 1'b0;
`endif

    assign halt_set = bus.halt_req | bp_hit;

    // Next state, halt flag and outputs are all decided for the coming cycle,
    // so the enable is high in the first cycle of the new state.
    always_comb begin
        state_d = mode_to_state(bus.mode);
        // Halted blocks the run modes; stepping stays available for debug.
        if ((halted_q || halt_set) && (state_d != StStep)) begin
            state_d = StHalt;
        end

        halted_d = halted_q;
        if (halt_set) begin
            halted_d = 1'b1;
        end else if (bus.mode == MODE_HALT) begin
            halted_d = 1'b0;
        end

        cpu_ce_d = 1'b0;
        unique case (state_d)
            StFast:  cpu_ce_d = 1'b1;
            StSlow:  cpu_ce_d = slow_tc;
            StStep:  cpu_ce_d = step_edge;
            default: cpu_ce_d = 1'b0;
        endcase

        running_d   = ((state_d == StSlow) || (state_d == StFast)) && !halted_d;
        cycle_cnt_d = cycle_cnt_q + CYC_W'(cpu_ce_q);
    end

    // Counting only while slow run is selected for the next cycle means the
    // tick restarts from 0 on every entry and is dropped on any exit.
    ce_rate_gen #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV)
    ) u_rate_gen (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (halt_set),
        .load_i   (bus.div_load),
        .val_i    (bus.div_val),
        .enable_i (state_d == StSlow),
        .tc_o     (slow_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHalt;
            cpu_ce_q    <= 1'b0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
            step_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_ce_q    <= cpu_ce_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            step_q      <= bus.step_btn;
        end
    end

    assign bus.cpu_ce    = cpu_ce_q;
    assign bus.running   = running_q;
    assign bus.halted    = halted_q;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cpu_clk_ctrl
// Directed bench for cpu_clk_ctrl. Small DEF_DIV and a 4-bit cycle counter so
// the reset divisor and counter wrap are visible in a short run.
// ----------------------------------------------------------------------------
module tb_cpu_clk_ctrl;

    localparam int unsigned DIV_W   = 32;
    localparam int unsigned CYC_W   = 4;
    localparam int unsigned DEF_DIV = 6;

    typedef struct packed {
        logic [1:0]  mode;
        logic        btn;
        logic        hr;
        logic        ld;
        logic [31:0] val;
        logic        ce;
        logic        run;
        logic        hlt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    vec_t tbl [26];

    cpu_clk_ctrl_if #(.DIV_W(DIV_W), .CYC_W(CYC_W)) bus ();

    cpu_clk_ctrl #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV),
        .CYC_W   (CYC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input int mode, input int btn, input int hr, input int ld,
                          input int val);
        bus.mode     = 2'(mode);
        bus.step_btn = 1'(btn);
        bus.halt_req = 1'(hr);
        bus.div_load = 1'(ld);
        bus.div_val  = DIV_W'(val);
    endtask

    function automatic vec_t mk(input int mode, input int btn, input int hr, input int ld,
                                input int val, input int ce, input int run, input int hlt);
        vec_t v;
        v.mode = 2'(mode);
        v.btn  = 1'(btn);
        v.hr   = 1'(hr);
        v.ld   = 1'(ld);
        v.val  = 32'(val);
        v.ce   = 1'(ce);
        v.run  = 1'(run);
        v.hlt  = 1'(hlt);
        return v;
    endfunction

    initial begin
        //          mode btn hr ld val  ce run hlt
        tbl[0]  = mk(3, 0, 0, 0, 0,  1, 1, 0);
        tbl[1]  = mk(3, 0, 0, 0, 0,  1, 1, 0);
        tbl[2]  = mk(3, 0, 1, 0, 0,  0, 0, 1);  // halt request stops fast run
        tbl[3]  = mk(3, 0, 0, 0, 0,  0, 0, 1);  // sticky
        tbl[4]  = mk(3, 0, 0, 0, 0,  0, 0, 1);
        tbl[5]  = mk(1, 0, 0, 0, 0,  0, 0, 1);
        tbl[6]  = mk(1, 1, 0, 0, 0,  1, 0, 1);  // step past halt
        tbl[7]  = mk(1, 1, 0, 0, 0,  0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 0,  0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0);  // halt mode clears
        tbl[10] = mk(0, 0, 1, 0, 0,  0, 0, 1);  // set wins over clear
        tbl[11] = mk(0, 0, 0, 0, 0,  0, 0, 0);
        tbl[12] = mk(3, 0, 0, 0, 0,  1, 1, 0);
        tbl[13] = mk(3, 0, 0, 0, 0,  1, 1, 0);
        tbl[14] = mk(2, 0, 0, 0, 0,  1, 1, 0);  // divisor still 1
        tbl[15] = mk(0, 0, 0, 0, 0,  0, 0, 0);
        tbl[16] = mk(0, 0, 0, 1, 4,  0, 0, 0);
        tbl[17] = mk(2, 0, 0, 0, 0,  0, 1, 0);
        tbl[18] = mk(2, 0, 0, 0, 0,  0, 1, 0);
        tbl[19] = mk(2, 0, 1, 0, 0,  0, 0, 1);  // pending tick discarded
        tbl[20] = mk(0, 0, 0, 0, 0,  0, 0, 0);
        tbl[21] = mk(2, 0, 0, 0, 0,  0, 1, 0);
        tbl[22] = mk(2, 0, 0, 0, 0,  0, 1, 0);
        tbl[23] = mk(2, 0, 0, 0, 0,  0, 1, 0);
        tbl[24] = mk(2, 0, 0, 0, 0,  1, 1, 0);  // full period after restart
        tbl[25] = mk(0, 0, 0, 0, 0,  0, 0, 0);

        set_in(0, 0, 0, 0, 0);
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
        bus.pc      = '0;
        bus.bp_wr   = 1'b0;
        bus.bp_addr = '0;
        bus.bp_on   = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("reset_ce", 32'(bus.cpu_ce), 0);
        check("reset_running", 32'(bus.running), 0);
        check("reset_halted", 32'(bus.halted), 0);
        check("reset_cnt", 32'(bus.cycle_cnt), 0);

        // Fast run: pulse every cycle from the first edge that samples mode 11.
        set_in(3, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("fast_ce[%0d]", i), 32'(bus.cpu_ce), 1);
            check($sformatf("fast_run[%0d]", i), 32'(bus.running), 1);
        end
        exp_cnt += 10;
        set_in(0, 0, 0, 0, 0);
        tick();
        check("fast_stop_ce", 32'(bus.cpu_ce), 0);
        check("fast_cnt", 32'(bus.cycle_cnt), 32'(exp_cnt % 16));

        // Slow run with divisor 4: one pulse every 4th cycle.
        set_in(0, 0, 0, 1, 4);
        tick();
        set_in(2, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("slow4_ce[%0d]", i), 32'(bus.cpu_ce), 32'((i % 4) == 3));
        end
        exp_cnt += 5;
        set_in(0, 0, 0, 0, 0);
        tick();
        check("slow4_stop_ce", 32'(bus.cpu_ce), 0);
        check("slow4_cnt", 32'(bus.cycle_cnt), 32'(exp_cnt % 16));

        // Divisor 0 is stored as 1: every cycle. Counter passes 15 -> 0 here.
        set_in(0, 0, 0, 1, 0);
        tick();
        set_in(2, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("slow1_ce[%0d]", i), 32'(bus.cpu_ce), 1);
            check($sformatf("wrap_cnt[%0d]", i), 32'(bus.cycle_cnt), 32'((exp_cnt + i) % 16));
        end
        exp_cnt += 20;
        set_in(0, 0, 0, 0, 0);
        tick();
        check("slow1_cnt", 32'(bus.cycle_cnt), 32'(exp_cnt % 16));

        // Step: three 7-cycle presses, one pulse each, on the press edge.
        set_in(1, 0, 0, 0, 0);
        tick();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 7; c++) begin
                set_in(1, 1, 0, 0, 0);
                tick();
                check($sformatf("step_ce[%0d][%0d]", p, c), 32'(bus.cpu_ce), 32'(c == 0));
            end
            for (int c = 0; c < 3; c++) begin
                set_in(1, 0, 0, 0, 0);
                tick();
                check($sformatf("step_rel_ce[%0d][%0d]", p, c), 32'(bus.cpu_ce), 0);
            end
        end
        exp_cnt += 3;

        // Button already held when entering step mode: no pulse.
        set_in(0, 1, 0, 0, 0);
        repeat (2) tick();
        for (int c = 0; c < 4; c++) begin
            set_in(1, 1, 0, 0, 0);
            tick();
            check($sformatf("held_ce[%0d]", c), 32'(bus.cpu_ce), 0);
        end
        set_in(0, 0, 0, 0, 0);
        tick();
        check("step_cnt", 32'(bus.cycle_cnt), 32'(exp_cnt % 16));

        // Halt / step-past-halt / clear / slow restart vectors.
        for (int r = 0; r < 26; r++) begin
            set_in(int'(tbl[r].mode), int'(tbl[r].btn), int'(tbl[r].hr), int'(tbl[r].ld),
                   int'(tbl[r].val));
            tick();
            check($sformatf("vec_ce[%0d]", r), 32'(bus.cpu_ce), 32'(tbl[r].ce));
            check($sformatf("vec_run[%0d]", r), 32'(bus.running), 32'(tbl[r].run));
            check($sformatf("vec_halted[%0d]", r), 32'(bus.halted), 32'(tbl[r].hlt));
            if (tbl[r].ce) exp_cnt++;
        end
        check("vec_cnt", 32'(bus.cycle_cnt), 32'(exp_cnt % 16));

        // Async reset mid slow run with divisor 5 and tick at 3.
        set_in(0, 0, 0, 1, 5);
        tick();
        set_in(2, 0, 0, 0, 0);
        repeat (3) tick();
        check("pre_rst_run", 32'(bus.running), 1);
        rst = 1'b1;
        #1;
        check("rst_slow_ce", 32'(bus.cpu_ce), 0);
        check("rst_slow_run", 32'(bus.running), 0);
        check("rst_slow_halted", 32'(bus.halted), 0);
        check("rst_slow_cnt", 32'(bus.cycle_cnt), 0);
        set_in(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_run", 32'(bus.running), 0);
        check("post_rst_ce", 32'(bus.cpu_ce), 0);

        // Reset divisor is DEF_DIV (6).
        set_in(2, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check($sformatf("defdiv_ce[%0d]", i), 32'(bus.cpu_ce), 32'((i % 6) == 5));
        end

        // Reset in the middle of a fast pulse drops it without a clock edge.
        set_in(3, 0, 0, 0, 0);
        repeat (2) tick();
        check("pre_rst_fast_ce", 32'(bus.cpu_ce), 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_fast_ce", 32'(bus.cpu_ce), 0);
        check("rst_fast_run", 32'(bus.running), 0);
        check("rst_fast_cnt", 32'(bus.cycle_cnt), 0);
        set_in(0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
